// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of one FIFO write port with occupancy-tracked backpressure.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          last,
  input  logic [NREQ*DW-1:0]       data_in,
  output logic [NREQ-1:0]          gnt,
  output logic                     fifo_wr_en,
  output logic [DW-1:0]            fifo_wr_data,
  input  logic                     fifo_rd_en,
  input  logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);
  localparam int NW = $clog2(NREQ);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [OW-1:0] DEPTH_V = OW'(DEPTH);
  localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BURST - 1);
  localparam logic [NW-1:0] LAST_REQ = NW'(NREQ - 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state;
  logic [NW-1:0] rr_ptr, pick;
  logic [BW-1:0] burst_cnt;
  logic space, push, pop, done;
  assign busy         = state == BURST;
  assign full         = occupancy == DEPTH_V;
  assign space        = occupancy < DEPTH_V;
  assign pop          = fifo_rd_en & ~fifo_empty;
  assign push         = busy & req[owner] & space;
  assign fifo_wr_en   = push;
  assign gnt          = push ? NREQ'(1) << owner : '0;
  assign fifo_wr_data = data_in[owner*DW +: DW];
  assign done         = (push & (last[owner] | burst_cnt == LAST_CNT)) | ~req[owner];
  // Descending scan so the requester closest to rr_ptr overrides the others.
  always_comb begin
    pick = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % NREQ]) pick = NW'((int'(rr_ptr) + k) % NREQ);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      occupancy <= '0;
    end else begin
      occupancy <= (push & ~pop) ? occupancy + 1'b1 :
                   (pop & ~push & |occupancy) ? occupancy - 1'b1 : occupancy;
      if (state == IDLE) begin
        if (|req) begin
          owner     <= pick;
          burst_cnt <= '0;
          state     <= BURST;
        end
      end else begin
        if (push) burst_cnt <= burst_cnt + 1'b1;
        if (done) begin
          rr_ptr <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
          state  <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic against a word-level reference model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4, DW = 32, DEPTH = 16, MAX_BURST = 4;
  logic clk = 0, rst = 1;
  logic [NREQ-1:0] req = '0, last = '0, gnt;
  logic [NREQ*DW-1:0] data_in = '0;
  logic fifo_wr_en, fifo_rd_en = 0, fifo_empty = 1, full, busy;
  logic [DW-1:0] fifo_wr_data;
  logic [4:0] occupancy;
  logic [1:0] owner;
  int n_cmp = 0, n_fail = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .data_in(data_in), .gnt(gnt),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en),
    .fifo_empty(fifo_empty), .occupancy(occupancy), .full(full), .owner(owner), .busy(busy));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic do_reset;
    rst = 0;
    req = '0; last = '0; fifo_rd_en = 0; fifo_empty = 1;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset;
    rst = 1; #1 rst = 0; #1;
    n_cmp++;
    if ({gnt, fifo_wr_en, full, busy, occupancy, owner} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0", {gnt, fifo_wr_en, full, busy, occupancy, owner});
    end
  endtask

  task automatic test_single_burst;
    do_reset;
    @(negedge clk); req = 4'b0010; data_in[DW +: DW] = 32'hAAAA0001; #1;
    n_cmp++;
    if ({gnt, busy, fifo_wr_en} !== 6'b0) begin n_fail++; $display("FAIL sb_arb got=%b exp=000000", {gnt, busy, fifo_wr_en}); end
    @(negedge clk); #1;
    n_cmp++;
    if ({gnt, fifo_wr_en, fifo_wr_data, occupancy} !== {4'b0010, 1'b1, 32'hAAAA0001, 5'd0}) begin
      n_fail++; $display("FAIL sb_word_a got=%b/%h/%0d exp=0010/aaaa0001/0", gnt, fifo_wr_data, occupancy);
    end
    @(negedge clk); data_in[DW +: DW] = 32'hBBBB0002; #1;
    n_cmp++;
    if ({gnt, fifo_wr_data, occupancy} !== {4'b0010, 32'hBBBB0002, 5'd1}) begin
      n_fail++; $display("FAIL sb_word_b got=%b/%h/%0d exp=0010/bbbb0002/1", gnt, fifo_wr_data, occupancy);
    end
    @(negedge clk); data_in[DW +: DW] = 32'hCCCC0003; last = 4'b0010; #1;
    n_cmp++;
    if ({gnt, fifo_wr_data, occupancy, owner} !== {4'b0010, 32'hCCCC0003, 5'd2, 2'd1}) begin
      n_fail++; $display("FAIL sb_word_c got=%b/%h/%0d/%0d exp=0010/cccc0003/2/1", gnt, fifo_wr_data, occupancy, owner);
    end
    @(negedge clk); req = '0; last = '0; #1;
    n_cmp++;
    if ({busy, gnt, occupancy} !== {1'b0, 4'b0, 5'd3}) begin
      n_fail++; $display("FAIL sb_idle got=%b/%b/%0d exp=0/0000/3", busy, gnt, occupancy);
    end
    @(negedge clk); req = 4'b1111; last = 4'b1111; #1;
    @(negedge clk); #1;
    n_cmp++;
    if ({owner, gnt} !== {2'd2, 4'b0100}) begin n_fail++; $display("FAIL sb_rr_next got=%0d/%b exp=2/0100", owner, gnt); end
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] e;
    do_reset;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin req = 4'b1111; last = 4'b1111; end
      #1;
      e = (i % 2 == 1) ? 4'b0001 << ((i / 2) % 4) : 4'b0000;
      n_cmp++;
      if ({gnt, busy} !== {e, i % 2 == 1}) begin
        n_fail++; $display("FAIL rr_cycle%0d got=%b/%b exp=%b/%b", i, gnt, busy, e, i % 2 == 1);
      end
      if (i % 2 == 1) begin
        n_cmp++;
        if (owner !== 2'((i / 2) % 4)) begin n_fail++; $display("FAIL rr_owner%0d got=%0d exp=%0d", i, owner, (i / 2) % 4); end
      end
    end
  endtask

  task automatic test_burst_cap;
    logic [NREQ-1:0] e;
    do_reset;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin req = 4'b0100; last = '0; end
      #1;
      e = (i == 0 || i == 5 || i == 10) ? 4'b0000 : 4'b0100;
      n_cmp++;
      if (gnt !== e) begin n_fail++; $display("FAIL cap_cycle%0d got=%b exp=%b", i, gnt, e); end
    end
    n_cmp++;
    if (occupancy !== 5'd8) begin n_fail++; $display("FAIL cap_occupancy got=%0d exp=8", occupancy); end
  endtask

  task automatic test_full_backpressure;
    int n = 0;
    do_reset;
    do begin @(negedge clk); req = 4'b0001; #1; n++; end while (!full && n < 40);
    n_cmp++;
    if ({full, occupancy} !== {1'b1, 5'd16}) begin n_fail++; $display("FAIL full_reach got=%b/%0d exp=1/16 after %0d cycles", full, occupancy, n); end
    @(negedge clk);
    repeat (3) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({gnt, busy, occupancy} !== {4'b0, 1'b1, 5'd16}) begin
        n_fail++; $display("FAIL full_stall got=%b/%b/%0d exp=0000/1/16", gnt, busy, occupancy);
      end
    end
    @(negedge clk); fifo_rd_en = 1; fifo_empty = 0; #1;
    n_cmp++;
    if (gnt !== 4'b0) begin n_fail++; $display("FAIL full_pop_nopush got=%b exp=0000", gnt); end
    @(negedge clk); fifo_rd_en = 0; #1;
    n_cmp++;
    if ({gnt, occupancy} !== {4'b0001, 5'd15}) begin n_fail++; $display("FAIL full_resume got=%b/%0d exp=0001/15", gnt, occupancy); end
    @(negedge clk); req = '0; #1;
    n_cmp++;
    if ({full, occupancy} !== {1'b1, 5'd16}) begin n_fail++; $display("FAIL full_refill got=%b/%0d exp=1/16", full, occupancy); end
  endtask

  task automatic test_push_pop;
    int n = 0;
    do_reset;
    do begin @(negedge clk); req = 4'b0001; #1; n++; end while (occupancy != 5'd8 && n < 40);
    @(negedge clk); fifo_rd_en = 1; fifo_empty = 0; #1;
    n_cmp++;
    if ({gnt, occupancy} !== {4'b0001, 5'd8}) begin n_fail++; $display("FAIL pp_both got=%b/%0d exp=0001/8", gnt, occupancy); end
    @(negedge clk); req = '0; fifo_rd_en = 0; #1;
    n_cmp++;
    if (occupancy !== 5'd8) begin n_fail++; $display("FAIL pp_hold got=%0d exp=8", occupancy); end
    do_reset;
    @(negedge clk); fifo_rd_en = 1; fifo_empty = 1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (occupancy !== 5'd0) begin n_fail++; $display("FAIL pp_empty_pop got=%0d exp=0", occupancy); end
    fifo_rd_en = 0;
  endtask

  task automatic test_withdraw;
    do_reset;
    @(negedge clk); req = 4'b1000; last = '0; #1;
    @(negedge clk); #1;
    n_cmp++;
    if (gnt !== 4'b1000) begin n_fail++; $display("FAIL wd_word0 got=%b exp=1000", gnt); end
    @(negedge clk); #1;
    n_cmp++;
    if ({gnt, occupancy} !== {4'b1000, 5'd1}) begin n_fail++; $display("FAIL wd_word1 got=%b/%0d exp=1000/1", gnt, occupancy); end
    @(negedge clk); req = '0; #1;
    n_cmp++;
    if ({gnt, busy} !== {4'b0, 1'b1}) begin n_fail++; $display("FAIL wd_drop got=%b/%b exp=0000/1", gnt, busy); end
    @(negedge clk); req = 4'b1001; last = 4'b1001; #1;
    n_cmp++;
    if ({busy, occupancy} !== {1'b0, 5'd2}) begin n_fail++; $display("FAIL wd_release got=%b/%0d exp=0/2", busy, occupancy); end
    @(negedge clk); #1;
    n_cmp++;
    if ({owner, gnt} !== {2'd0, 4'b0001}) begin n_fail++; $display("FAIL wd_rr_ptr got=%0d/%b exp=0/0001", owner, gnt); end
  endtask

  task automatic test_async_reset;
    int n = 0;
    do_reset;
    do begin @(negedge clk); req = 4'b0001; last = '0; #1; n++; end while (occupancy != 5'd5 && n < 40);
    n_cmp++;
    if ({busy, gnt} !== {1'b1, 4'b0001}) begin n_fail++; $display("FAIL ar_midburst got=%b/%b exp=1/0001", busy, gnt); end
    #2 rst = 0; #1;
    n_cmp++;
    if ({gnt, fifo_wr_en, full, busy, occupancy, owner} !== 14'd0) begin
      n_fail++; $display("FAIL ar_async_clear got=%h exp=0", {gnt, fifo_wr_en, full, busy, occupancy, owner});
    end
    @(negedge clk); rst = 1; #1;
    n_cmp++;
    if ({fifo_wr_en, occupancy} !== 6'd0) begin n_fail++; $display("FAIL ar_after_release got=%b/%0d exp=0/0", fifo_wr_en, occupancy); end
    @(negedge clk); #1;
    n_cmp++;
    if ({gnt, occupancy} !== {4'b0001, 5'd0}) begin n_fail++; $display("FAIL ar_regrant got=%b/%0d exp=0001/0", gnt, occupancy); end
    req = '0;
  endtask

  task automatic test_random;
    int m_occ = 0, m_owner = 0, m_rr = 0, m_words = 0;
    bit m_busy = 0, e_push, pop, found;
    logic [NREQ-1:0] e_gnt, acc = '0;
    do_reset;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          data_in[i*DW +: DW] = $urandom;
          req[i] = 1'($urandom_range(0, 1));
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin req[i] = 1; data_in[i*DW +: DW] = $urandom; end
        end else if ($urandom_range(0, 31) == 0) req[i] = 0;
        last[i] = $urandom_range(0, 3) == 0;
      end
      fifo_rd_en = (c < 400) ? $urandom_range(0, 4) == 0 : $urandom_range(0, 1) == 0;
      fifo_empty = m_occ == 0;
      #1;
      e_push = m_busy && req[m_owner] && m_occ < DEPTH;
      e_gnt = e_push ? NREQ'(1) << m_owner : '0;
      n_cmp++;
      if ({gnt, fifo_wr_en} !== {e_gnt, e_push}) begin
        n_fail++; $display("FAIL rnd_gnt c=%0d got=%b/%b exp=%b/%b", c, gnt, fifo_wr_en, e_gnt, e_push);
      end
      if (e_push) begin
        n_cmp++;
        if (fifo_wr_data !== data_in[m_owner*DW +: DW]) begin
          n_fail++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, fifo_wr_data, data_in[m_owner*DW +: DW]);
        end
      end
      n_cmp++;
      if ({occupancy, full, busy, owner} !== {5'(m_occ), m_occ == DEPTH, m_busy, 2'(m_owner)}) begin
        n_fail++; $display("FAIL rnd_state c=%0d got=%0d/%b/%b/%0d exp=%0d/%b/%b/%0d",
                           c, occupancy, full, busy, owner, m_occ, m_occ == DEPTH, m_busy, m_owner);
      end
      acc = e_gnt;
      pop = fifo_rd_en && !fifo_empty;
      m_occ = m_occ + int'(e_push) - int'(pop);
      if (m_occ < 0) m_occ = 0;
      if (m_occ > DEPTH) m_occ = DEPTH;
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < NREQ; k++)
          if (!found && req[(m_rr + k) % NREQ]) begin m_owner = (m_rr + k) % NREQ; found = 1; end
        if (found) begin m_busy = 1; m_words = 0; end
      end else begin
        if (e_push) m_words++;
        if ((e_push && (last[m_owner] || m_words == MAX_BURST)) || !req[m_owner]) begin
          m_busy = 0;
          m_rr = (m_owner + 1) % NREQ;
        end
      end
    end
    req = '0; last = '0; fifo_rd_en = 0;
  endtask

  initial begin
    test_reset;
    test_single_burst;
    test_round_robin;
    test_burst_cap;
    test_full_backpressure;
    test_push_pop;
    test_withdraw;
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
